// File: rtl/dwc_retry_controller.sv
// Sequencing controller for a duplicated-with-comparison datapath unit: drives one
// operand, waits the pipeline latency, checks the comparator, re-runs on mismatch.
module dwc_retry_controller #(
  parameter int   DATA_W    = 2,
  parameter int   LATENCY   = 1,
  parameter int   MAX_RETRY = 2,
  parameter logic ERR_POL   = 1'b0,
  parameter int   CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] dp_in,
  input  logic              dp_out,
  input  logic              dp_error,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_data,
  output logic              out_err,
  output logic              fault,
  output logic [CNT_W-1:0]  err_count,
  input  logic              clr_fault,
  output logic [1:0]        dbg_state
);

  localparam int WCW = $clog2(LATENCY + 1);
  localparam int RW  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Handshakes: a transfer happens on a rising edge where valid && ready; in_ready and
  // out_valid come from registered state only, and out_data/out_err hold while out_valid.
  state_t              state_q, state_d;
  logic [DATA_W-1:0]   dp_in_q, dp_in_d;
  logic [WCW-1:0]      wait_cnt_q, wait_cnt_d;
  logic [RW-1:0]       retry_q, retry_d;
  logic                out_data_q, out_data_d;
  logic                out_err_q, out_err_d;
  logic                fault_q, fault_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;
  logic                mismatch;

  assign mismatch = (dp_error == ERR_POL);

  always_comb begin
    state_d     = state_q;
    dp_in_d     = dp_in_q;
    wait_cnt_d  = wait_cnt_q;
    retry_d     = retry_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    fault_d     = fault_q;
    err_count_d = err_count_q;

    // Clear first so that a mismatch in the same cycle is applied on top of it.
    if (clr_fault) begin
      fault_d     = 1'b0;
      err_count_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid && !fault_q) begin
          dp_in_d    = in_data;
          wait_cnt_d = WCW'(LATENCY);
          retry_d    = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q - WCW'(1);
        if (wait_cnt_q == WCW'(1)) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (!mismatch) begin
          out_data_d = dp_out;
          out_err_d  = 1'b0;
          state_d    = S_RESP;
        end else begin
          if (err_count_d != {CNT_W{1'b1}}) err_count_d = err_count_d + CNT_W'(1);
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d    = retry_q + RW'(1);
            wait_cnt_d = WCW'(LATENCY);
            state_d    = S_WAIT;
          end else begin
            fault_d    = 1'b1;
            out_data_d = dp_out;
            out_err_d  = 1'b1;
            state_d    = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dp_in_q     <= '0;
      wait_cnt_q  <= '0;
      retry_q     <= '0;
      out_data_q  <= 1'b0;
      out_err_q   <= 1'b0;
      fault_q     <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      dp_in_q     <= dp_in_d;
      wait_cnt_q  <= wait_cnt_d;
      retry_q     <= retry_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      fault_q     <= fault_d;
      err_count_q <= err_count_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !fault_q;
  assign out_valid = (state_q == S_RESP);
  assign dp_in     = dp_in_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign fault     = fault_q;
  assign err_count = err_count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dwc_retry_controller.sv
// Bench for dwc_retry_controller: the bench plays the DwC unit cycle by cycle and
// scoreboards returned results, latencies, counters and the fault flag.
module tb_dwc_retry_controller;

  localparam int   DATA_W    = 2;
  localparam int   LATENCY   = 1;
  localparam int   MAX_RETRY = 2;
  localparam logic EP        = 1'b0;
  localparam int   CNT_W     = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [DATA_W-1:0] dp_in;
  logic              dp_out = 1'b0;
  logic              dp_error = ~EP;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_data;
  logic              out_err;
  logic              fault;
  logic [CNT_W-1:0]  err_count;
  logic              clr_fault = 1'b0;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  logic [1:0]       exp_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  logic             exp_fault = 1'b0;

  dwc_retry_controller #(
    .DATA_W(DATA_W), .LATENCY(LATENCY), .MAX_RETRY(MAX_RETRY), .ERR_POL(EP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .dp_in(dp_in), .dp_out(dp_out), .dp_error(dp_error), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_err(out_err), .fault(fault),
    .err_count(err_count), .clr_fault(clr_fault), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Starts and ends on a falling edge. n_mis leading CHECKs see a mismatch; clr_at
  // pulses clr_fault during that CHECK index; hold keeps out_ready low in RESP.
  task automatic run_op(input logic [DATA_W-1:0] data, input int n_mis, input logic dpo,
                        input int clr_at, input int hold, input string name);
    int m_used;
    logic exhausted;
    int exp_cyc;
    int k;
    int idx;
    logic [1:0] exp_v;
    exhausted = (n_mis > MAX_RETRY);
    m_used    = exhausted ? MAX_RETRY + 1 : n_mis;
    exp_cyc   = (exhausted ? m_used : m_used + 1) * (LATENCY + 1) + 1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready_idle: got %b exp 1", name, in_ready);
    end
    exp_q.push_back({dpo, exhausted});
    for (int i = 0; i < m_used; i++) begin
      if (i == clr_at) begin
        exp_cnt   = '0;
        exp_fault = 1'b0;
      end
      if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    end
    if (exhausted) exp_fault = 1'b1;

    dp_out    = dpo;
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_data   = data;
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_data = ~data;
    @(negedge clk);
    k = 1;
    while (out_valid !== 1'b1 && k < 40) begin
      clr_fault = 1'b0;
      dp_error  = ~EP;
      if (k % (LATENCY + 1) == 0) begin
        idx = k / (LATENCY + 1) - 1;
        if (idx < n_mis) dp_error = EP;
        if (idx == clr_at) clr_fault = 1'b1;
      end else begin
        checks++;
        if (dp_in !== data) begin
          errors++;
          $display("FAIL %s dp_in_hold: got %0d exp %0d", name, dp_in, data);
        end
      end
      @(negedge clk);
      k++;
    end
    clr_fault = 1'b0;
    dp_error  = ~EP;

    checks++;
    if (k != exp_cyc) begin
      errors++;
      $display("FAIL %s out_valid_cycle: got %0d exp %0d", name, k, exp_cyc);
    end
    if (out_valid === 1'b1 && exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if ({out_data, out_err} !== exp_v) begin
        errors++;
        $display("FAIL %s result: got data=%b err=%b exp data=%b err=%b",
                 name, out_data, out_err, exp_v[1], exp_v[0]);
      end
    end
    checks++;
    if (err_count !== exp_cnt || fault !== exp_fault || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s status: got cnt=%0d fault=%b in_ready=%b exp cnt=%0d fault=%b in_ready=0",
               name, err_count, fault, in_ready, exp_cnt, exp_fault);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || {out_data, out_err} !== {dpo, exhausted} || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s backpressure: got v=%b d=%b e=%b rdy=%b exp v=1 d=%b e=%b rdy=0",
                 name, out_valid, out_data, out_err, in_ready, dpo, exhausted);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== !exp_fault) begin
      errors++;
      $display("FAIL %s after_resp: got v=%b rdy=%b exp v=0 rdy=%b",
               name, out_valid, in_ready, !exp_fault);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_cnt   = '0;
    exp_fault = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || fault !== 1'b0 || err_count !== '0 || dp_in !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: got v=%b f=%b cnt=%0d dp_in=%0d rdy=%b exp 0 0 0 0 1",
               out_valid, fault, err_count, dp_in, in_ready);
    end
  endtask

  task automatic test_clean();
    run_op(2'b11, 0, 1'b1, -1, 0, "clean");
  endtask

  task automatic test_transient();
    run_op(2'b01, 1, 1'b0, -1, 0, "transient");
  endtask

  task automatic test_permanent();
    logic [DATA_W-1:0] last;
    run_op(2'b10, 3, 1'b1, -1, 0, "permanent");
    last = dp_in;
    in_valid = 1'b1;
    in_data  = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || dp_in !== last) begin
        errors++;
        $display("FAIL blocked: got rdy=%b v=%b dp_in=%0d exp rdy=0 v=0 dp_in=%0d",
                 in_ready, out_valid, dp_in, last);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_recovery();
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    exp_cnt   = '0;
    exp_fault = 1'b0;
    checks++;
    if (fault !== 1'b0 || err_count !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear: got f=%b cnt=%0d rdy=%b exp 0 0 1", fault, err_count, in_ready);
    end
    run_op(2'b10, 1, 1'b1, -1, 0, "pre_clr");
    run_op(2'b01, 1, 1'b0, 0, 0, "clr_in_check");
  endtask

  task automatic test_backpressure();
    run_op(2'b11, 2, 1'b1, -1, 5, "backpressure");
  endtask

  task automatic test_rst_mid();
    in_valid = 1'b1;
    in_data  = 2'b11;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt   = '0;
    exp_fault = 1'b0;
    checks++;
    if (dp_in !== '0 || in_ready !== 1'b1 || err_count !== '0) begin
      errors++;
      $display("FAIL rst_mid: got dp_in=%0d rdy=%b cnt=%0d exp 0 1 0", dp_in, in_ready, err_count);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_no_out: got out_valid=%b exp 0", out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      run_op(DATA_W'($urandom_range(0, 3)), int'($urandom_range(0, MAX_RETRY)),
             1'($urandom_range(0, 1)), -1, 0, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_transient();
    test_permanent();
    test_recovery();
    test_backpressure();
    test_rst_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
